// File: rtl/apb_req_arb.sv
// apb_req_arb: round-robin arbiter sharing one req/ack bridge between N
// requesters. Adds locked bursts bounded by MAX_BURST and a GRANT watchdog
// that aborts a transfer the bridge never acknowledges.
module apb_req_arb #(
    parameter int N         = 4,
    parameter int AW        = 16,
    parameter int DW        = 16,
    parameter int MAX_BURST = 4,
    parameter int TIMEOUT   = 1024
) (
    input  logic            pclk,
    input  logic            preset,
    input  logic [N-1:0]    req,
    input  logic [N-1:0]    wr_req,
    input  logic [N-1:0]    lock,
    input  logic [N*AW-1:0] addr_req,
    input  logic [N*DW-1:0] data_send,
    output logic [N-1:0]    ack,
    output logic [N-1:0]    err,
    output logic [N-1:0]    grant,
    output logic [DW-1:0]   data_reciv,
    output logic            m_req,
    output logic            m_wr_req,
    output logic [AW-1:0]   m_addr_req,
    output logic [DW-1:0]   m_data_send,
    input  logic [DW-1:0]   m_data_reciv,
    input  logic            m_ack,
    input  logic            m_complete
);

    localparam int LW  = $clog2(N);
    localparam int BCW = (MAX_BURST > 32'sd1) ? $clog2(MAX_BURST) : 32'sd1;
    localparam int WDW = (TIMEOUT > 32'sd1) ? $clog2(TIMEOUT) : 32'sd1;
    localparam bit WD_EN = (TIMEOUT != 32'sd0);
    localparam logic [BCW-1:0] BURST_LAST = BCW'(MAX_BURST - 32'sd1);
    localparam logic [WDW-1:0] WD_LAST    = WDW'(TIMEOUT - 32'sd1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t          state_r, state_s;
    logic [N-1:0]    grant_r, grant_s;
    logic [N-1:0]    ack_r, ack_s;
    logic [N-1:0]    err_r, err_s;
    logic [DW-1:0]   data_reciv_r, data_reciv_s;
    logic            m_req_r, m_req_s;
    logic            m_wr_req_r, m_wr_req_s;
    logic [AW-1:0]   m_addr_r, m_addr_s;
    logic [DW-1:0]   m_data_r, m_data_s;
    logic [LW-1:0]   last_r, last_s;
    logic            owned_r, owned_s;   // a previous owner exists since reset
    logic [BCW-1:0]  burst_cnt_r, burst_cnt_s;
    logic [WDW-1:0]  wdog_r, wdog_s;

    logic [AW-1:0]   addr_arr_s [N];
    logic [DW-1:0]   data_arr_s [N];
    logic [LW-1:0]   cand_s     [N];
    logic            rr_found_s;
    logic [LW-1:0]   rr_idx_s;
    logic            lock_cont_s;
    logic [LW-1:0]   win_s;
    logic            timeout_s;

    // Unpack the flattened request buses and the round-robin search order.
    always_comb begin
        for (int i = 32'sd0; i < N; i++) begin
            addr_arr_s[i] = addr_req[i*AW +: AW];
            data_arr_s[i] = data_send[i*DW +: DW];
            cand_s[i]     = LW'((int'(last_r) + i + 32'sd1) % N);
        end
    end

    // Winner: locked continuation of the previous owner, else first requester after last.
    always_comb begin
        rr_found_s = 1'b0;
        rr_idx_s   = '0;
        for (int i = 32'sd0; i < N; i++) begin
            if (!rr_found_s && req[cand_s[i]]) begin
                rr_found_s = 1'b1;
                rr_idx_s   = cand_s[i];
            end else begin
                rr_found_s = rr_found_s;
            end
        end
        lock_cont_s = owned_r && lock[last_r] && req[last_r] && (burst_cnt_r < BURST_LAST);
        if (lock_cont_s) begin
            win_s = last_r;
        end else begin
            win_s = rr_idx_s;
        end
        timeout_s = WD_EN && (wdog_r == WD_LAST);
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_s      = state_r;
        grant_s      = grant_r;
        ack_s        = '0;
        err_s        = '0;
        data_reciv_s = data_reciv_r;
        m_req_s      = m_req_r;
        m_wr_req_s   = m_wr_req_r;
        m_addr_s     = m_addr_r;
        m_data_s     = m_data_r;
        last_s       = last_r;
        owned_s      = owned_r;
        burst_cnt_s  = burst_cnt_r;
        wdog_s       = wdog_r;
        case (state_r)
            ST_IDLE: begin
                if ((|req) && m_complete) begin
                    state_s    = ST_GRANT;
                    grant_s    = {{(N-1){1'b0}}, 1'b1} << win_s;
                    m_req_s    = 1'b1;
                    m_wr_req_s = wr_req[win_s];
                    m_addr_s   = addr_arr_s[win_s];
                    m_data_s   = data_arr_s[win_s];
                    last_s     = win_s;
                    owned_s    = 1'b1;
                    wdog_s     = '0;
                    if (lock_cont_s) begin
                        burst_cnt_s = burst_cnt_r + 1'b1;
                    end else begin
                        burst_cnt_s = '0;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (m_ack) begin
                    // A real ack beats a watchdog expiry in the same cycle.
                    state_s      = ST_RELEASE;
                    ack_s        = grant_r;
                    data_reciv_s = m_data_reciv;
                    m_req_s      = 1'b0;
                end else if (timeout_s) begin
                    state_s = ST_RELEASE;
                    err_s   = grant_r;
                    m_req_s = 1'b0;
                end else begin
                    wdog_s = wdog_r + 1'b1;
                end
            end
            ST_RELEASE: begin
                if (m_complete) begin
                    state_s = ST_IDLE;
                    grant_s = '0;
                end else begin
                    state_s = ST_RELEASE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                grant_s = '0;
                m_req_s = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state_r      <= ST_IDLE;
            grant_r      <= '0;
            ack_r        <= '0;
            err_r        <= '0;
            data_reciv_r <= '0;
            m_req_r      <= 1'b0;
            m_wr_req_r   <= 1'b0;
            m_addr_r     <= '0;
            m_data_r     <= '0;
            last_r       <= LW'(N - 32'sd1);
            owned_r      <= 1'b0;
            burst_cnt_r  <= '0;
            wdog_r       <= '0;
        end else begin
            state_r      <= state_s;
            grant_r      <= grant_s;
            ack_r        <= ack_s;
            err_r        <= err_s;
            data_reciv_r <= data_reciv_s;
            m_req_r      <= m_req_s;
            m_wr_req_r   <= m_wr_req_s;
            m_addr_r     <= m_addr_s;
            m_data_r     <= m_data_s;
            last_r       <= last_s;
            owned_r      <= owned_s;
            burst_cnt_r  <= burst_cnt_s;
            wdog_r       <= wdog_s;
        end
    end

    assign ack         = ack_r;
    assign err         = err_r;
    assign grant       = grant_r;
    assign data_reciv  = data_reciv_r;
    assign m_req       = m_req_r;
    assign m_wr_req    = m_wr_req_r;
    assign m_addr_req  = m_addr_r;
    assign m_data_send = m_data_r;

endmodule

// File: doc/apb_req_arb.md
# apb_req_arb

Round-robin arbiter that shares the single `apb_master` request bridge between N requesters, e.g. an SD init sequencer, a CPU port and a DMA engine, all reaching `sd_spi` registers over `pbus`. Each requester uses the bridge's own req/ack protocol. The arbiter forwards exactly one granted request at a time and returns ack and read data to the winner. It adds per-requester locked bursts with starvation bound and a watchdog that aborts hung transfers.

## Interface
- `N`, 4: number of requesters (2..8).
- `AW`, 16: address width.
- `DW`, 16: data width.
- `MAX_BURST`, 4: max consecutive grants to one locked requester (≥1).
- `TIMEOUT`, 1024: cycles in GRANT without `m_ack` before abort; 0 disables.

Ports:
- `pclk` in 1: clock.
- `preset` in 1: synchronous, active-high reset.
- `req` in N: per-requester request, held until `ack`/`err`.
- `wr_req` in N: 1 = write, 0 = read.
- `lock` in N: request to keep grant for the next transaction.
- `addr_req` in N*AW: flattened addresses; slice i = `[i*AW +: AW]`.
- `data_send` in N*DW: flattened write data.
- `ack` out N: one-cycle registered completion pulse to winner.
- `err` out N: one-cycle registered timeout pulse to winner.
- `grant` out N: one-hot registered current owner, 0 when idle.
- `data_reciv` out DW: read data, valid in the `ack` cycle, held until the next ack.
- `m_req`, `m_wr_req` out 1: to bridge `req`/`wr_req`.
- `m_addr_req` out AW: to bridge address.
- `m_data_send` out DW: to bridge write data.
- `m_data_reciv` in DW: from bridge.
- `m_ack` in 1: bridge transfer-done pulse.
- `m_complete` in 1: bridge idle (level).

## Operation
- States:
  - IDLE: sample `req`.
  - GRANT: `m_req` high, wait for `m_ack`.
  - RELEASE: `m_req` low, wait for bridge idle.
- IDLE → GRANT when any `req` is high and `m_complete` is 1.
  - Winner chosen, `grant`/`m_*` registered.
  - `m_addr_req`/`m_wr_req`/`m_data_send` are latched from the winner's slice at grant and held constant through GRANT.
- Winner selection:
  - Locked continuation: if previous owner p has `lock[p]` and `req[p]` high, and `burst_cnt < MAX_BURST-1`, p wins and `burst_cnt` increments.
  - Otherwise round-robin: search starts at `last+1` mod N, first requester with `req` high wins, `burst_cnt` clears to 0.
  - `last` updates to the winner.
- GRANT → RELEASE on `m_ack`:
  - `ack[g]` <= 1 and `data_reciv` <= `m_data_reciv` (write: still captured, don't-care).
  - `m_req` <= 0.
- GRANT → RELEASE on timeout:
  - Condition: `TIMEOUT` ≠ 0 and the watchdog reaches `TIMEOUT-1` with no `m_ack`.
  - `err[g]` <= 1, `m_req` <= 0, `data_reciv` unchanged.
  - `m_ack` and timeout in the same cycle: `m_ack` wins, no `err`.
- RELEASE → IDLE when `m_complete` is 1. `ack`/`err` clear after one cycle regardless. `grant` <= 0 on leaving RELEASE.
- `m_ack` outside GRANT (late ack after abort) is ignored: no `ack`, no `data_reciv` update.
- `req` is sampled only in IDLE. Deasserting `req` during GRANT does not cancel the transfer; the ack is still issued.
- `lock` on a requester not currently owning is ignored for selection.

## Timing
- Reset values:
  - `ack`, `err`, `grant` = 0.
  - `m_req`, `m_wr_req` = 0.
  - `m_addr_req`, `m_data_send`, `data_reciv` = 0.
  - state = IDLE, `last` = N-1 (first search starts at 0), `burst_cnt` = 0, watchdog = 0.
- Reset is honoured in any state, including mid-GRANT: `m_req` drops the next cycle and no `ack`/`err` is issued. The bridge is expected to be reset by the same `preset`.
- Request latency: `req` high and sampled at edge t in IDLE → `grant` and `m_req` high from cycle t+1.
- Ack latency: `m_ack` sampled at edge k → `ack[g]` high in cycle k+1 only. IDLE is re-entered no earlier than cycle k+2.
  - Requesters must update or drop `req`/`addr`/`data` by edge k+1.
  - Requests sampled in IDLE are therefore always fresh.
- Minimum back-to-back spacing: 3 cycles between consecutive `m_req` rises (GRANT ≥1, RELEASE ≥1, IDLE 1).
- Watchdog counts GRANT cycles, starting at 0 on entry. Abort produces `err` at cycle entry+TIMEOUT.

## Test plan
- Single read: `req[1]`=1, `addr`=0x0003, bridge acks after 20 cycles with 0x00A5 → `grant`=0b0010 at +1, `m_addr_req`=0x0003, `ack[1]` one pulse, `data_reciv`=0x00A5.
- Simultaneous: all four `req` high from reset → grants in order 0,1,2,3, each with exactly one `ack`, `m_req` never high for two owners.
- Round-robin: after a grant to 2, `req[0]` and `req[3]` high → 3 granted before 0.
- Locked burst (`MAX_BURST`=4): `lock[0]` and `req[0]` held, `req[2]` high → four consecutive grants to 0, then 2, then 0.
- Timeout (`TIMEOUT`=16): bridge never acks → `err[g]` at cycle 16 after grant, `m_req` low, no `ack`. A late `m_ack` is ignored, and the next requester is served normally.
- Reset mid-GRANT: assert `preset` 5 cycles into a transfer → all outputs 0 next cycle, no `ack`. After release of reset, the pending `req[0]` is granted fresh.
